hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Each cycle it generates enable/flush for the PC register, the IF/ID register and the ID/EX register.
- Resolves load-use hazards, taken-branch/jump redirects, instruction-fetch wait states and data-memory busy holds.
- Keeps saturating stall and flush performance counters. Sits beside the datapath, driven from ID, ID/EX and EX stage signals.

Parameters:
- XLEN, 32 (from RISCV.h), width of the performance counters.
- REG_ADDR_W, 5, register index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_ADDR_W  rs1 index of instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 index of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- idex_rd  in  REG_ADDR_W  destination of instruction in EX.
- idex_mem_read  in  1  instruction in EX is a load.
- ex_redirect  in  1  EX resolved taken branch or jump.
- imem_ready  in  1  instruction memory returns valid word this cycle.
- dmem_busy  in  1  data memory not done; back end must hold.
- pc_enable  out  1  PC register load enable.
- if_id_enable  out  1  enable of IF/ID register.
- if_id_flush  out  1  synchronous clear of IF/ID.
- id_ex_flush  out  1  synchronous clear of ID/EX (bubble insert).
- stall_active  out  1  any stall in effect this cycle.
- stall_count  out  XLEN  cycles with pc_enable=0.
- flush_count  out  XLEN  number of redirect events.

Behaviour:
- State register, 2 bits: RUN, DMEM_HOLD, REDIRECT_WAIT. All outputs are combinational from state plus inputs. Counters and state are registered.
- Reset low (asynchronous):
  - state=RUN; stall_count=0; flush_count=0.
  - Outputs forced to pc_enable=0, if_id_enable=0, if_id_flush=0, id_ex_flush=0, stall_active=0.
  - Release is synchronous to the next clock edge.
- load_use = idex_mem_read && idex_rd!=0 && ((id_use_rs1 && id_rs1==idex_rd) || (id_use_rs2 && id_rs2==idex_rd)).
- Priority in RUN, highest first:
  1. dmem_busy: pc_enable=0, if_id_enable=0, no flushes. Next state DMEM_HOLD.
  2. ex_redirect:
     - pc_enable=1 (PC takes target), if_id_flush=1, id_ex_flush=1; flush_count++.
     - If imem_ready=0, next state REDIRECT_WAIT.
  3. load_use: pc_enable=0, if_id_enable=0, id_ex_flush=1. Exactly one bubble; the hazard clears itself the next cycle.
  4. !imem_ready: pc_enable=0, if_id_enable=1, if_id_flush=1 (bubble into ID, back end advances).
  5. Otherwise pc_enable=1, if_id_enable=1.
- DMEM_HOLD:
  - All held as in priority 1 while dmem_busy=1.
  - When dmem_busy=0, outputs follow the RUN rules this same cycle and state returns to RUN.
  - ex_redirect is ignored while dmem_busy=1. EX is frozen, so it is re-seen after release.
- REDIRECT_WAIT:
  - pc_enable=0, if_id_flush=1, id_ex_flush=0 until imem_ready=1.
  - Then normal RUN outputs apply and state returns to RUN.
  - dmem_busy in this state goes to DMEM_HOLD with if_id_flush kept 1.
  - A new ex_redirect here is handled as in RUN priority 2.
- stall_active = !pc_enable && state!=reset.
- Counters:
  - stall_count increments on each clock where pc_enable=0, excluding reset.
  - flush_count increments once per accepted redirect.
  - Both saturate at all-ones and never wrap.
- Simultaneous load_use and ex_redirect: redirect wins, because the ID instruction is squashed. No bubble is counted for load_use.
- idex_rd=0 never causes a stall.

Decomposition:
- Shared package/header (RISCV.h): XLEN, REG_ADDR_W, state encodings HC_RUN=0, HC_DMEM_HOLD=1, HC_REDIRECT_WAIT=2.
- One sub-module: sat_counter (parameterised width, inc, synchronous saturate, async active-low clear). Instantiated twice.

Test Plan:
- Reset low mid-stall with stall_count=5 -> outputs zero immediately; after release state RUN, counts 0.
- load_use with idex_rd=7, id_rs2=7, id_use_rs2=1 -> exactly one cycle pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_count=1. Repeat with idex_rd=0 -> no stall.
- ex_redirect and load_use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_enable=1, flush_count=1, stall_count unchanged.
- dmem_busy high 4 cycles with ex_redirect held -> 4 frozen cycles, stall_count=4. Then redirect is taken on the release cycle, flush_count=1.
- ex_redirect with imem_ready=0 for 3 cycles -> REDIRECT_WAIT, if_id_flush=1 each cycle, stall_count=3. Normal flow when imem_ready=1.
- Preload counters near saturation (force 0xFFFFFFFE) and stall 3 cycles -> stall_count=0xFFFFFFFF, no wrap.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared widths and FSM encoding for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    HC_RUN           = 2'd0,
    HC_DMEM_HOLD     = 2'd1,
    HC_REDIRECT_WAIT = 2'd2
  } hc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; asynchronous active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: PC / IF-ID / ID-EX enables
// and flushes, plus saturating stall and redirect counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int REG_ADDR_W_P = REG_ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [REG_ADDR_W_P-1:0] id_rs1,
  input  logic [REG_ADDR_W_P-1:0] id_rs2,
  input  logic                    id_use_rs1,
  input  logic                    id_use_rs2,
  input  logic [REG_ADDR_W_P-1:0] idex_rd,
  input  logic                    idex_mem_read,
  input  logic                    ex_redirect,
  input  logic                    imem_ready,
  input  logic                    dmem_busy,
  output logic                    pc_enable,
  output logic                    if_id_enable,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic                    stall_active,
  output logic [XLEN_P-1:0]       stall_count,
  output logic [XLEN_P-1:0]       flush_count,
  output hc_state_e               state_dbg
);

  // Valid/ready note: this block has no handshakes of its own; imem_ready and
  // dmem_busy are level qualifiers sampled every cycle, never acknowledged.

  hc_state_e state_q, state_d;

  logic load_use;
  logic pc_en_raw, if_id_en_raw, if_id_flush_raw, id_ex_flush_raw;
  logic redirect_take;

  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == idex_rd)) ||
                     (id_use_rs2 && (id_rs2 == idex_rd)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HC_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect is deferred while the back end is frozen, so it is re-seen on release.
  always_comb begin
    state_d = HC_RUN;
    if (dmem_busy) begin
      state_d = HC_DMEM_HOLD;
    end else if (ex_redirect && !imem_ready) begin
      state_d = HC_REDIRECT_WAIT;
    end else if ((state_q == HC_REDIRECT_WAIT) && !imem_ready) begin
      state_d = HC_REDIRECT_WAIT;
    end
  end

  always_comb begin
    pc_en_raw       = 1'b0;
    if_id_en_raw    = 1'b0;
    if_id_flush_raw = 1'b0;
    id_ex_flush_raw = 1'b0;
    redirect_take   = 1'b0;
    if (dmem_busy) begin
      if_id_flush_raw = (state_q == HC_REDIRECT_WAIT);
    end else if (ex_redirect) begin
      pc_en_raw       = 1'b1;
      if_id_en_raw    = 1'b1;
      if_id_flush_raw = 1'b1;
      id_ex_flush_raw = 1'b1;
      redirect_take   = 1'b1;
    end else if ((state_q == HC_REDIRECT_WAIT) && !imem_ready) begin
      if_id_en_raw    = 1'b1;
      if_id_flush_raw = 1'b1;
    end else if (load_use) begin
      id_ex_flush_raw = 1'b1;
    end else if (!imem_ready) begin
      if_id_en_raw    = 1'b1;
      if_id_flush_raw = 1'b1;
    end else begin
      pc_en_raw       = 1'b1;
      if_id_en_raw    = 1'b1;
    end
  end

  assign pc_enable    = reset && pc_en_raw;
  assign if_id_enable = reset && if_id_en_raw;
  assign if_id_flush  = reset && if_id_flush_raw;
  assign id_ex_flush  = reset && id_ex_flush_raw;
  assign stall_active = reset && !pc_en_raw;
  assign state_dbg    = state_q;

  sat_counter #(.W(XLEN_P)) u_stall_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .inc_i   (stall_active),
    .count_o (stall_count)
  );

  sat_counter #(.W(XLEN_P)) u_flush_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .inc_i   (reset && redirect_take),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a narrow-counter second instance covers saturation.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_use_rs1, id_use_rs2, idex_mem_read;
  logic       ex_redirect, imem_ready, dmem_busy;

  logic        pc_enable, if_id_enable, if_id_flush, id_ex_flush, stall_active;
  logic [31:0] stall_count, flush_count;
  hc_state_e   state_dbg;

  logic        s_pc_enable, s_if_id_enable, s_if_id_flush, s_id_ex_flush, s_stall_active;
  logic [3:0]  s_stall_count, s_flush_count;
  hc_state_e   s_state_dbg;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  hazard_ctrl u_dut (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .ex_redirect(ex_redirect),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy), .pc_enable(pc_enable),
    .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .stall_active(stall_active),
    .stall_count(stall_count), .flush_count(flush_count), .state_dbg(state_dbg)
  );

  hazard_ctrl #(.XLEN_P(4)) u_small (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .ex_redirect(ex_redirect),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy), .pc_enable(s_pc_enable),
    .if_id_enable(s_if_id_enable), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .stall_active(s_stall_active),
    .stall_count(s_stall_count), .flush_count(s_flush_count), .state_dbg(s_state_dbg)
  );

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; idex_mem_read = 1'b0;
    ex_redirect = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    cycle();
    checks++; if (pc_enable !== 1'b0) begin fails++; $display("FAIL rst_pc got %b exp 0", pc_enable); end
    checks++; if (if_id_enable !== 1'b0) begin fails++; $display("FAIL rst_ifid_en got %b exp 0", if_id_enable); end
    checks++; if (stall_active !== 1'b0) begin fails++; $display("FAIL rst_stall_active got %b exp 0", stall_active); end
    reset = 1'b1;
    dmem_busy = 1'b1;
    repeat (5) cycle();
    checks++; if (stall_count !== 32'd5) begin fails++; $display("FAIL pre_stall_cnt got %0d exp 5", stall_count); end
    checks++; if (state_dbg !== HC_DMEM_HOLD) begin fails++; $display("FAIL pre_state got %0d exp 1", state_dbg); end
    // Assert reset away from a clock edge: effects must be immediate.
    #2 reset = 1'b0;
    #1;
    checks++; if ({pc_enable, if_id_enable, if_id_flush, id_ex_flush, stall_active} !== 5'b0) begin
      fails++; $display("FAIL midrst_outs got %b exp 00000",
                        {pc_enable, if_id_enable, if_id_flush, id_ex_flush, stall_active}); end
    checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL midrst_cnt got %0d exp 0", stall_count); end
    checks++; if (state_dbg !== HC_RUN) begin fails++; $display("FAIL midrst_state got %0d exp 0", state_dbg); end
    cycle();
    dmem_busy = 1'b0;
    reset = 1'b1;
    cycle();
    checks++; if (state_dbg !== HC_RUN) begin fails++; $display("FAIL rel_state got %0d exp 0", state_dbg); end
    checks++; if (pc_enable !== 1'b1) begin fails++; $display("FAIL rel_pc got %b exp 1", pc_enable); end
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      fails++; $display("FAIL rel_cnts got %0d/%0d exp 0/0", stall_count, flush_count); end
  endtask

  task automatic test_load_use();
    apply_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    #1;
    checks++; if ({pc_enable, if_id_enable, id_ex_flush, if_id_flush} !== 4'b0010) begin
      fails++; $display("FAIL lu_outs got %b exp 0010", {pc_enable, if_id_enable, id_ex_flush, if_id_flush}); end
    cycle();
    idex_mem_read = 1'b0; idex_rd = 5'd0;
    #1;
    checks++; if (pc_enable !== 1'b1 || id_ex_flush !== 1'b0) begin
      fails++; $display("FAIL lu_clear got pc=%b idex=%b exp 1/0", pc_enable, id_ex_flush); end
    cycle();
    checks++; if (stall_count !== 32'd1) begin fails++; $display("FAIL lu_cnt got %0d exp 1", stall_count); end
    idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
    #1;
    checks++; if (pc_enable !== 1'b1 || id_ex_flush !== 1'b0) begin
      fails++; $display("FAIL lu_x0 got pc=%b idex=%b exp 1/0", pc_enable, id_ex_flush); end
    cycle();
    idex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    #1;
    checks++; if (pc_enable !== 1'b1) begin fails++; $display("FAIL lu_unused got %b exp 1", pc_enable); end
    id_use_rs1 = 1'b1;
    #1;
    checks++; if (pc_enable !== 1'b0 || id_ex_flush !== 1'b1) begin
      fails++; $display("FAIL lu_rs1 got pc=%b idex=%b exp 0/1", pc_enable, id_ex_flush); end
    cycle();
    idle_inputs();
    cycle();
    checks++; if (stall_count !== 32'd2) begin fails++; $display("FAIL lu_cnt2 got %0d exp 2", stall_count); end
  endtask

  task automatic test_redirect_vs_load_use();
    apply_reset();
    idex_mem_read = 1'b1; idex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
    #1;
    checks++; if ({pc_enable, if_id_flush, id_ex_flush} !== 3'b111) begin
      fails++; $display("FAIL rlu_outs got %b exp 111", {pc_enable, if_id_flush, id_ex_flush}); end
    cycle();
    idle_inputs();
    cycle();
    checks++; if (flush_count !== 32'd1) begin fails++; $display("FAIL rlu_flush got %0d exp 1", flush_count); end
    checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL rlu_stall got %0d exp 0", stall_count); end
  endtask

  task automatic test_dmem_hold();
    apply_reset();
    dmem_busy = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({pc_enable, if_id_enable, if_id_flush, id_ex_flush} !== 4'b0000) begin
        fails++; $display("FAIL dh_frozen%0d got %b exp 0000", i,
                          {pc_enable, if_id_enable, if_id_flush, id_ex_flush}); end
      cycle();
    end
    checks++; if (state_dbg !== HC_DMEM_HOLD) begin fails++; $display("FAIL dh_state got %0d exp 1", state_dbg); end
    checks++; if (flush_count !== 32'd0) begin fails++; $display("FAIL dh_noflush got %0d exp 0", flush_count); end
    dmem_busy = 1'b0;
    #1;
    checks++; if ({pc_enable, if_id_flush, id_ex_flush} !== 3'b111) begin
      fails++; $display("FAIL dh_release got %b exp 111", {pc_enable, if_id_flush, id_ex_flush}); end
    cycle();
    ex_redirect = 1'b0;
    checks++; if (stall_count !== 32'd4) begin fails++; $display("FAIL dh_stall got %0d exp 4", stall_count); end
    checks++; if (flush_count !== 32'd1) begin fails++; $display("FAIL dh_flush got %0d exp 1", flush_count); end
    checks++; if (state_dbg !== HC_RUN) begin fails++; $display("FAIL dh_state2 got %0d exp 0", state_dbg); end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    imem_ready = 1'b0;
    #1;
    checks++; if ({pc_enable, if_id_enable, if_id_flush, id_ex_flush} !== 4'b0110) begin
      fails++; $display("FAIL fetch_wait got %b exp 0110", {pc_enable, if_id_enable, if_id_flush, id_ex_flush}); end
    ex_redirect = 1'b1;
    #1;
    checks++; if (pc_enable !== 1'b1) begin fails++; $display("FAIL rw_take got %b exp 1", pc_enable); end
    cycle();
    ex_redirect = 1'b0;
    checks++; if (state_dbg !== HC_REDIRECT_WAIT) begin fails++; $display("FAIL rw_state got %0d exp 2", state_dbg); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({pc_enable, if_id_flush, id_ex_flush, stall_active} !== 4'b0101) begin
        fails++; $display("FAIL rw_wait%0d got %b exp 0101", i, {pc_enable, if_id_flush, id_ex_flush, stall_active}); end
      cycle();
    end
    imem_ready = 1'b1;
    #1;
    checks++; if ({pc_enable, if_id_enable, if_id_flush} !== 3'b110) begin
      fails++; $display("FAIL rw_resume got %b exp 110", {pc_enable, if_id_enable, if_id_flush}); end
    cycle();
    checks++; if (stall_count !== 32'd3) begin fails++; $display("FAIL rw_stall got %0d exp 3", stall_count); end
    checks++; if (flush_count !== 32'd1) begin fails++; $display("FAIL rw_flush got %0d exp 1", flush_count); end
    checks++; if (state_dbg !== HC_RUN) begin fails++; $display("FAIL rw_state2 got %0d exp 0", state_dbg); end
    // A data-memory hold arriving during the fetch wait keeps the IF/ID flush.
    ex_redirect = 1'b1; imem_ready = 1'b0;
    cycle();
    ex_redirect = 1'b0; dmem_busy = 1'b1;
    #1;
    checks++; if ({pc_enable, if_id_enable, if_id_flush, id_ex_flush} !== 4'b0010) begin
      fails++; $display("FAIL rw_dmem got %b exp 0010", {pc_enable, if_id_enable, if_id_flush, id_ex_flush}); end
    cycle();
    checks++; if (state_dbg !== HC_DMEM_HOLD) begin fails++; $display("FAIL rw_dmem_state got %0d exp 1", state_dbg); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_saturate();
    apply_reset();
    dmem_busy = 1'b1;
    repeat (13) cycle();
    checks++; if (s_stall_count !== 4'hD) begin fails++; $display("FAIL sat_pre got %0h exp d", s_stall_count); end
    repeat (3) cycle();
    checks++; if (s_stall_count !== 4'hF) begin fails++; $display("FAIL sat_top got %0h exp f", s_stall_count); end
    repeat (3) cycle();
    checks++; if (s_stall_count !== 4'hF) begin fails++; $display("FAIL sat_hold got %0h exp f", s_stall_count); end
    checks++; if (stall_count !== 32'd19) begin fails++; $display("FAIL sat_wide got %0d exp 19", stall_count); end
    dmem_busy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ex_redirect = 1'b1;
      cycle();
    end
    ex_redirect = 1'b0;
    checks++; if (s_flush_count !== 4'hF) begin fails++; $display("FAIL sat_flush got %0h exp f", s_flush_count); end
    checks++; if (flush_count !== 32'd17) begin fails++; $display("FAIL sat_flush_wide got %0d exp 17", flush_count); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_vs_load_use();
    test_dmem_hold();
    test_redirect_wait();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
